vga_rd_arbiter: RTL and testbench

VGA_RD_ARBITER -- requirements
Module: vga_rd_arbiter

---
 rtl/vga_pkg.sv | 14 +
 rtl/vga_rr_prio.sv | 26 ++
 rtl/vga_rd_arbiter.sv | 122 ++++++++++++
 tb/tb_vga_rd_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared FSM encoding, AXI burst/response codes and arbiter defaults
package vga_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;
    localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/vga_rr_prio.sv
// vga_rr_prio: fixed m0 priority with a starvation counter that hands m1 a turn
module vga_rr_prio
    import vga_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt_valid,
    output logic gnt_sel
);
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    logic [CW-1:0] starve_cnt;
    logic          starved;
    assign starved   = starve_cnt == CW'(STARVE_LIMIT);
    assign gnt_sel   = req1 && (!req0 || starved);
    assign gnt_valid = en && (req0 || req1);
    // count m0 wins taken while m1 waits; any m1 win clears the debt
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) starve_cnt <= '0;
        else if (gnt_valid)
            starve_cnt <= gnt_sel ? '0 : (req1 && !starved) ? starve_cnt + 1'b1 : starve_cnt;
endmodule

// File: rtl/vga_rd_arbiter.sv
// vga_rd_arbiter: two-master AXI read arbiter with a single outstanding burst
module vga_rd_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  m0_arvalid_i,
    output logic                  m0_arready_o,
    input  logic [ADDR_WIDTH-1:0] m0_araddr_i,
    input  logic [1:0]            m0_arburst_i,
    input  logic [7:0]            m0_arlen_i,
    input  logic [2:0]            m0_arsize_i,
    output logic                  m0_rvalid_o,
    output logic [1:0]            m0_rresp_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    output logic                  m0_rlast_o,
    input  logic                  m0_rready_i,
    input  logic                  m1_arvalid_i,
    output logic                  m1_arready_o,
    input  logic [ADDR_WIDTH-1:0] m1_araddr_i,
    input  logic [1:0]            m1_arburst_i,
    input  logic [7:0]            m1_arlen_i,
    input  logic [2:0]            m1_arsize_i,
    output logic                  m1_rvalid_o,
    output logic [1:0]            m1_rresp_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  m1_rlast_o,
    input  logic                  m1_rready_i,
    output logic                  s_arvalid_o,
    output logic [ADDR_WIDTH-1:0] s_araddr_o,
    output logic [1:0]            s_arburst_o,
    output logic [7:0]            s_arlen_o,
    output logic [2:0]            s_arsize_o,
    input  logic                  s_arready_i,
    input  logic                  s_rvalid_i,
    input  logic [1:0]            s_rresp_i,
    input  logic [DATA_WIDTH-1:0] s_rdata_i,
    input  logic                  s_rlast_i,
    output logic                  s_rready_o,
    output logic                  busy_o,
    output logic                  gnt_o,
    output logic                  err_o
);
    logic [1:0]            state, state_nxt;
    logic                  gnt_q, err_q, gnt_valid, gnt_sel, idle, data, r_hs, at_len;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            burst_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [8:0]            beat_q, beat_nxt;

    assign idle = state == ST_IDLE;
    assign data = state == ST_DATA;

    vga_rr_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk       (clk),
        .resetn    (resetn),
        .en        (idle && resetn),
        .req0      (m0_arvalid_i),
        .req1      (m1_arvalid_i),
        .gnt_valid (gnt_valid),
        .gnt_sel   (gnt_sel)
    );

    assign m0_arready_o = gnt_valid && !gnt_sel;
    assign m1_arready_o = gnt_valid && gnt_sel;
    assign s_arvalid_o  = state == ST_ADDR;
    assign s_araddr_o   = addr_q;
    assign s_arburst_o  = burst_q;
    assign s_arlen_o    = len_q;
    assign s_arsize_o   = size_q;
    assign s_rready_o   = data && (gnt_q ? m1_rready_i : m0_rready_i);
    assign m0_rvalid_o  = data && !gnt_q && s_rvalid_i;
    assign m1_rvalid_o  = data && gnt_q && s_rvalid_i;
    assign m0_rdata_o   = s_rdata_i;
    assign m1_rdata_o   = s_rdata_i;
    assign m0_rresp_o   = s_rresp_i;
    assign m1_rresp_o   = s_rresp_i;
    assign m0_rlast_o   = s_rlast_i;
    assign m1_rlast_o   = s_rlast_i;
    assign busy_o       = !idle;
    assign gnt_o        = gnt_q;
    assign err_o        = err_q;
    assign r_hs         = s_rready_o && s_rvalid_i;
    assign beat_nxt     = beat_q + 9'd1;
    assign at_len       = beat_nxt == {1'b0, len_q} + 9'd1;

    // one burst at a time: grant, issue the address, drain beats until rlast
    always_comb
        state_nxt = idle ? (gnt_valid ? ST_ADDR : ST_IDLE)
                  : (state == ST_ADDR) ? (s_arready_i ? ST_DATA : ST_ADDR)
                  : data ? ((r_hs && s_rlast_i) ? ST_IDLE : ST_DATA)
                  : ST_IDLE;

    // capture the winner's payload, count beats and flag length disagreements
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state   <= ST_IDLE;
            gnt_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            burst_q <= '0;
            len_q   <= '0;
            size_q  <= '0;
            beat_q  <= '0;
        end else begin
            state <= state_nxt;
            err_q <= r_hs && (s_rlast_i ? !at_len : at_len);
            beat_q <= gnt_valid ? 9'd0 : r_hs ? beat_nxt : beat_q;
            if (gnt_valid) begin
                gnt_q   <= gnt_sel;
                addr_q  <= gnt_sel ? m1_araddr_i : m0_araddr_i;
                burst_q <= gnt_sel ? m1_arburst_i : m0_arburst_i;
                len_q   <= gnt_sel ? m1_arlen_i : m0_arlen_i;
                size_q  <= gnt_sel ? m1_arsize_i : m0_arsize_i;
            end
        end
endmodule

// File: tb/tb_vga_rd_arbiter.sv
// tb_vga_rd_arbiter: randomized scenario bench with a behavioural arbitration model
module tb_vga_rd_arbiter;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          m0_arvalid_i, m0_arready_o, m0_rvalid_o, m0_rlast_o, m0_rready_i;
    logic [AW-1:0] m0_araddr_i;
    logic [1:0]    m0_arburst_i, m0_rresp_o;
    logic [7:0]    m0_arlen_i;
    logic [2:0]    m0_arsize_i;
    logic [DW-1:0] m0_rdata_o;
    logic          m1_arvalid_i, m1_arready_o, m1_rvalid_o, m1_rlast_o, m1_rready_i;
    logic [AW-1:0] m1_araddr_i;
    logic [1:0]    m1_arburst_i, m1_rresp_o;
    logic [7:0]    m1_arlen_i;
    logic [2:0]    m1_arsize_i;
    logic [DW-1:0] m1_rdata_o;
    logic          s_arvalid_o, s_arready_i, s_rvalid_i, s_rlast_i, s_rready_o;
    logic [AW-1:0] s_araddr_o;
    logic [1:0]    s_arburst_o, s_rresp_i;
    logic [7:0]    s_arlen_o;
    logic [2:0]    s_arsize_o;
    logic [DW-1:0] s_rdata_i;
    logic          busy_o, gnt_o, err_o;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    vga_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .resetn(resetn),
        .m0_arvalid_i(m0_arvalid_i), .m0_arready_o(m0_arready_o), .m0_araddr_i(m0_araddr_i),
        .m0_arburst_i(m0_arburst_i), .m0_arlen_i(m0_arlen_i), .m0_arsize_i(m0_arsize_i),
        .m0_rvalid_o(m0_rvalid_o), .m0_rresp_o(m0_rresp_o), .m0_rdata_o(m0_rdata_o),
        .m0_rlast_o(m0_rlast_o), .m0_rready_i(m0_rready_i),
        .m1_arvalid_i(m1_arvalid_i), .m1_arready_o(m1_arready_o), .m1_araddr_i(m1_araddr_i),
        .m1_arburst_i(m1_arburst_i), .m1_arlen_i(m1_arlen_i), .m1_arsize_i(m1_arsize_i),
        .m1_rvalid_o(m1_rvalid_o), .m1_rresp_o(m1_rresp_o), .m1_rdata_o(m1_rdata_o),
        .m1_rlast_o(m1_rlast_o), .m1_rready_i(m1_rready_i),
        .s_arvalid_o(s_arvalid_o), .s_araddr_o(s_araddr_o), .s_arburst_o(s_arburst_o),
        .s_arlen_o(s_arlen_o), .s_arsize_o(s_arsize_o), .s_arready_i(s_arready_i),
        .s_rvalid_i(s_rvalid_i), .s_rresp_i(s_rresp_i), .s_rdata_i(s_rdata_i),
        .s_rlast_i(s_rlast_i), .s_rready_o(s_rready_o),
        .busy_o(busy_o), .gnt_o(gnt_o), .err_o(err_o)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        {m0_arvalid_i, m1_arvalid_i, m0_rready_i, m1_rready_i} = '0;
        {m0_araddr_i, m1_araddr_i, m0_arburst_i, m1_arburst_i} = '0;
        {m0_arlen_i, m1_arlen_i, m0_arsize_i, m1_arsize_i} = '0;
        {s_arready_i, s_rvalid_i, s_rlast_i, s_rresp_i, s_rdata_i} = '0;
    endtask

    function automatic bit model_pick(input bit r0, input bit r1);
        return r1 && (!r0 || model_cnt == LIM);
    endfunction

    function automatic void model_grant(input bit r1, input bit w);
        if (w) model_cnt = 0;
        else if (r1 && model_cnt < LIM) model_cnt++;
    endfunction

    function automatic int model_errs(input int len, input int n);
        return (n < len + 1) ? 1 : (n == len + 1) ? 0 : 2;
    endfunction

    task automatic issue(input bit r0, input bit r1, input bit keep, output bit g0, output bit g1);
        m0_arvalid_i = r0;
        m1_arvalid_i = r1;
        #1;
        g0 = m0_arready_o;
        g1 = m1_arready_o;
        tick();
        if (!keep) begin
            m0_arvalid_i = 1'b0;
            m1_arvalid_i = 1'b0;
        end
    endtask

    task automatic serve(input int ar_delay, input int nbeats, input bit who, output int bad, output int errs);
        logic [AW-1:0] a;
        logic [7:0]    l;
        bit            rdy;
        int            b, cyc;
        bad = 0;
        errs = 0;
        a = s_araddr_o;
        l = s_arlen_o;
        for (int i = 0; i < ar_delay; i++) begin
            #1;
            if (s_arvalid_o !== 1'b1 || s_araddr_o !== a || s_arlen_o !== l || m0_arready_o || m1_arready_o) bad++;
            tick();
        end
        s_arready_i = 1'b1;
        #1;
        if (s_arvalid_o !== 1'b1) bad++;
        tick();
        s_arready_i = 1'b0;
        b = 0;
        cyc = 0;
        while (b < nbeats && cyc < 40 * nbeats + 50) begin
            s_rvalid_i = $urandom_range(0, 3) != 0;
            s_rdata_i  = {$urandom, $urandom};
            s_rresp_i  = 2'($urandom);
            s_rlast_i  = b == nbeats - 1;
            rdy = $urandom_range(0, 3) != 0;
            m0_rready_i = who ? 1'($urandom) : rdy;
            m1_rready_i = who ? rdy : 1'($urandom);
            #1;
            if ((who ? m1_rvalid_o : m0_rvalid_o) !== s_rvalid_i || (who ? m0_rvalid_o : m1_rvalid_o) !== 1'b0
                || s_rready_o !== rdy || m0_arready_o || m1_arready_o || busy_o !== 1'b1 || s_arvalid_o) bad++;
            if (s_rvalid_i && ((who ? m1_rdata_o : m0_rdata_o) !== s_rdata_i
                || (who ? m1_rresp_o : m0_rresp_o) !== s_rresp_i || (who ? m1_rlast_o : m0_rlast_o) !== s_rlast_i)) bad++;
            if (s_rvalid_i && rdy) b++;
            tick();
            errs += int'(err_o);
            cyc++;
        end
        if (b < nbeats) bad++;
        {s_rvalid_i, s_rlast_i, m0_rready_i, m1_rready_i} = '0;
    endtask

    task automatic test_reset;
        checks++;
        if ({busy_o, gnt_o, err_o, s_arvalid_o, m0_arready_o, m1_arready_o, m0_rvalid_o, m1_rvalid_o, s_rready_o} !== 9'b0
            || s_araddr_o !== '0 || s_arlen_o !== '0)
            $display("FAIL reset_held got busy=%b gnt=%b err=%b arvalid=%b addr=%h want all 0", busy_o, gnt_o, err_o, s_arvalid_o, s_araddr_o);
        resetn = 1'b1;
        tick();
        checks++;
        if (busy_o !== 1'b0 || s_arvalid_o !== 1'b0 || err_o !== 1'b0)
            $display("FAIL reset_release got busy=%b arvalid=%b err=%b want 0 0 0", busy_o, s_arvalid_o, err_o);
        if (errors != errors) ;
    endtask

    task automatic test_single;
        bit g0, g1;
        int bad, errs;
        m0_araddr_i = 64'h1000;
        m0_arlen_i = 8'd3;
        m0_arburst_i = 2'd1;
        m0_arsize_i = 3'd3;
        issue(1'b1, 1'b0, 1'b0, g0, g1);
        model_grant(1'b0, 1'b0);
        checks++;
        if (g0 !== 1'b1 || g1 !== 1'b0) begin errors++; $display("FAIL single_arready got m0=%b m1=%b want 1 0", g0, g1); end
        checks++;
        if (s_arvalid_o !== 1'b1 || s_araddr_o !== 64'h1000 || s_arlen_o !== 8'd3 || s_arburst_o !== 2'd1
            || s_arsize_o !== 3'd3 || gnt_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_addr got arvalid=%b addr=%h len=%0d gnt=%b busy=%b want 1 1000 3 0 1", s_arvalid_o, s_araddr_o, s_arlen_o, gnt_o, busy_o);
        end
        serve(0, 4, 1'b0, bad, errs);
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL single_beats got %0d bad cycles want 0", bad); end
        checks++;
        if (errs !== 0 || busy_o !== 1'b0) begin errors++; $display("FAIL single_end got err_pulses=%0d busy=%b want 0 0", errs, busy_o); end
    endtask

    task automatic test_starve;
        bit g0, g1, w;
        int bad, errs, tot;
        logic [AW-1:0] ea;
        tot = 0;
        m0_arlen_i = 8'd0;
        m1_arlen_i = 8'd0;
        for (int i = 0; i < 12; i++) begin
            m0_araddr_i = {$urandom, $urandom};
            m1_araddr_i = {$urandom, $urandom};
            w = model_pick(1'b1, 1'b1);
            ea = w ? m1_araddr_i : m0_araddr_i;
            issue(1'b1, 1'b1, 1'b1, g0, g1);
            model_grant(1'b1, w);
            checks++;
            if (g0 !== !w || g1 !== w || gnt_o !== w || s_araddr_o !== ea) begin
                errors++;
                $display("FAIL starve_order[%0d] got m0=%b m1=%b gnt=%b addr=%h want m1=%b addr=%h", i, g0, g1, gnt_o, s_araddr_o, w, ea);
            end
            serve(0, 1, w, bad, errs);
            tot += bad + errs;
        end
        m0_arvalid_i = 1'b0;
        m1_arvalid_i = 1'b0;
        checks++;
        if (tot !== 0) begin errors++; $display("FAIL starve_bursts got %0d bad want 0", tot); end
    endtask

    task automatic test_ar_stall;
        bit g0, g1;
        int bad, errs;
        m1_araddr_i = {$urandom, $urandom};
        m1_arlen_i = 8'd2;
        issue(1'b0, 1'b1, 1'b0, g0, g1);
        model_grant(1'b1, 1'b1);
        checks++;
        if (g1 !== 1'b1 || g0 !== 1'b0 || s_araddr_o !== m1_araddr_i) begin
            errors++;
            $display("FAIL stall_grant got m1=%b addr=%h want 1 %h", g1, s_araddr_o, m1_araddr_i);
        end
        m0_arvalid_i = 1'b1;
        serve(5, 3, 1'b1, bad, errs);
        m0_arvalid_i = 1'b0;
        checks++;
        if (bad !== 0 || errs !== 0) begin errors++; $display("FAIL stall_hold got bad=%0d err_pulses=%0d want 0 0", bad, errs); end
    endtask

    task automatic test_short_burst;
        bit g0, g1;
        int bad, errs;
        m0_araddr_i = 64'h2000;
        m0_arlen_i = 8'd7;
        issue(1'b1, 1'b0, 1'b0, g0, g1);
        model_grant(1'b0, 1'b0);
        serve(1, 4, 1'b0, bad, errs);
        checks++;
        if (errs !== 1) begin errors++; $display("FAIL short_err got %0d pulses want 1", errs); end
        checks++;
        if (bad !== 0 || busy_o !== 1'b0) begin errors++; $display("FAIL short_idle got bad=%0d busy=%b want 0 0", bad, busy_o); end
    endtask

    task automatic test_random;
        bit g0, g1, r0, r1, w;
        int bad, errs, n, len;
        logic [AW-1:0] ea;
        logic [7:0]    el;
        logic [1:0]    eb;
        logic [2:0]    es;
        for (int i = 0; i < 40; i++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            m0_araddr_i = {$urandom, $urandom};
            m1_araddr_i = {$urandom, $urandom};
            m0_arlen_i = 8'($urandom_range(0, 7));
            m1_arlen_i = 8'($urandom_range(0, 7));
            m0_arburst_i = 2'($urandom);
            m1_arburst_i = 2'($urandom);
            m0_arsize_i = 3'($urandom);
            m1_arsize_i = 3'($urandom);
            w = model_pick(r0, r1);
            ea = w ? m1_araddr_i : m0_araddr_i;
            el = w ? m1_arlen_i : m0_arlen_i;
            eb = w ? m1_arburst_i : m0_arburst_i;
            es = w ? m1_arsize_i : m0_arsize_i;
            issue(r0, r1, 1'b0, g0, g1);
            model_grant(r1, w);
            checks++;
            if (g0 !== !w || g1 !== w) begin errors++; $display("FAIL rand_grant[%0d] got m0=%b m1=%b want m1=%b", i, g0, g1, w); end
            checks++;
            if (s_araddr_o !== ea || s_arlen_o !== el || s_arburst_o !== eb || s_arsize_o !== es || gnt_o !== w || s_arvalid_o !== 1'b1) begin
                errors++;
                $display("FAIL rand_payload[%0d] got addr=%h len=%0d gnt=%b want %h %0d %b", i, s_araddr_o, s_arlen_o, gnt_o, ea, el, w);
            end
            len = int'(el);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 3) : len + 1;
            serve($urandom_range(0, 3), n, w, bad, errs);
            checks++;
            if (bad !== 0) begin errors++; $display("FAIL rand_route[%0d] got %0d bad cycles want 0", i, bad); end
            checks++;
            if (errs !== model_errs(len, n)) begin
                errors++;
                $display("FAIL rand_err[%0d] got %0d pulses want %0d (len=%0d beats=%0d)", i, errs, model_errs(len, n), len, n);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit g0, g1;
        int bad, errs;
        m1_araddr_i = {$urandom, $urandom};
        m1_arlen_i = 8'd7;
        issue(1'b0, 1'b1, 1'b0, g0, g1);
        s_arready_i = 1'b1;
        tick();
        s_arready_i = 1'b0;
        m1_rready_i = 1'b1;
        s_rvalid_i = 1'b1;
        s_rdata_i = {$urandom, $urandom};
        tick();
        resetn = 1'b0;
        #1;
        checks++;
        if ({busy_o, gnt_o, err_o, s_arvalid_o, m0_arready_o, m1_arready_o, m0_rvalid_o, m1_rvalid_o, s_rready_o} !== 9'b0
            || s_araddr_o !== '0 || s_arlen_o !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got busy=%b gnt=%b m1_rvalid=%b addr=%h len=%0d want all 0", busy_o, gnt_o, m1_rvalid_o, s_araddr_o, s_arlen_o);
        end
        model_cnt = 0;
        idle_inputs();
        tick();
        resetn = 1'b1;
        tick();
        m1_araddr_i = {$urandom, $urandom};
        m1_arlen_i = 8'd1;
        issue(1'b0, 1'b1, 1'b0, g0, g1);
        model_grant(1'b1, 1'b1);
        checks++;
        if (g1 !== 1'b1 || gnt_o !== 1'b1 || s_araddr_o !== m1_araddr_i || s_arlen_o !== 8'd1) begin
            errors++;
            $display("FAIL midreset_regrant got m1=%b gnt=%b addr=%h want 1 1 %h", g1, gnt_o, s_araddr_o, m1_araddr_i);
        end
        serve(0, 2, 1'b1, bad, errs);
        checks++;
        if (bad !== 0 || errs !== 0) begin errors++; $display("FAIL midreset_burst got bad=%0d err_pulses=%0d want 0 0", bad, errs); end
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        test_reset();
        test_single();
        test_starve();
        test_ar_stall();
        test_short_burst();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule
